// File: rtl/mem_arbiter.sv
// mem_arbiter: shares a single-port unified RAM between the instruction
// fetch port and the data port. Data accesses normally win. Fetch is forced
// after STARVE_MAX consecutive data completions that happened while a fetch
// was pending. One RAM access is in flight at a time, and the RAM ends it by
// pulsing ramready.
//
// Ports:
//   CLK, nRST                 clock, asynchronous active-low reset
//   iREN, iaddr               instruction read request and address
//   iwait, iload              instruction stall and returned word
//   dREN, dWEN, daddr, dstore data read/write request, address, write data
//   dwait, dload              data stall and returned read data
//   ramREN, ramWEN            RAM strobes
//   ramaddr, ramstore         RAM address and write data
//   ramload, ramready         RAM read data and access-complete pulse
module mem_arbiter #(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic        iwait,
  output logic [31:0] iload,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        dwait,
  output logic [31:0] dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic        ramready
);

  localparam int unsigned CW = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {
    IDLE,
    IGRANT,
    DGRANT
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_starve_cnt;

  logic w_dreq;
  logic w_idone;
  logic w_ddone;
  logic w_force_fetch;

  assign w_dreq        = dREN | dWEN;
  // A completion needs the granted requester to still be asking. If the
  // requester has dropped, this is an abort and any ramready is ignored.
  assign w_idone       = (r_state == IGRANT) & iREN & ramready;
  assign w_ddone       = (r_state == DGRANT) & w_dreq & ramready;
  assign w_force_fetch = iREN & (r_starve_cnt == CW'(STARVE_MAX));

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state      <= IDLE;
      r_starve_cnt <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (!iREN) r_starve_cnt <= '0;
          if (w_dreq && !w_force_fetch) r_state <= DGRANT;
          else if (iREN)                r_state <= IGRANT;
        end
        IGRANT: begin
          if (!iREN) begin
            r_state <= IDLE;
          end else if (ramready) begin
            r_starve_cnt <= '0;
            r_state      <= IDLE;
          end
        end
        DGRANT: begin
          if (!w_dreq) begin
            r_state <= IDLE;
          end else if (ramready) begin
            r_state <= IDLE;
            if (!iREN)
              r_starve_cnt <= '0;
            else if (r_starve_cnt != CW'(STARVE_MAX))
              r_starve_cnt <= r_starve_cnt + CW'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Outputs are decoded from the registered state. They are not registered
  // themselves, because completion and strobe drop must be seen in the same
  // cycle as ramready or the request drop.
  always_comb begin
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    case (r_state)
      IGRANT: begin
        ramaddr = iaddr;
        ramREN  = iREN;
      end
      DGRANT: begin
        ramaddr = daddr;
        if (dWEN) begin
          ramWEN   = 1'b1;
          ramstore = dstore;
        end else begin
          ramREN = dREN;
        end
      end
      default: ;
    endcase
    iwait = iREN & ~w_idone;
    dwait = w_dreq & ~w_ddone;
    iload = w_idone ? ramload : '0;
    dload = (w_ddone & ~dWEN) ? ramload : '0;
  end

endmodule
